// File: rtl/exe_stage_core_if.sv
// ID/EX input bundle and EXE/MEM output bundle of the execute stage.
// master drives control/operands/forwarding and reads results; slave is the stage.
interface exe_stage_core_if;
    logic        freeze;
    logic        WB_EN_IN;
    logic        MEM_R_EN_IN;
    logic        MEM_W_EN_IN;
    logic        B_IN;
    logic        S_IN;
    logic [3:0]  EXE_CMD_IN;
    logic [31:0] PC_IN;
    logic [31:0] Val_Rn_IN;
    logic [31:0] Val_Rm_IN;
    logic        imm_IN;
    logic [11:0] Shift_operand_IN;
    logic [23:0] Signed_imm_24_IN;
    logic [3:0]  Dest_IN;
    logic [1:0]  sel_src1;
    logic [1:0]  sel_src2;
    logic [31:0] MEM_fwd;
    logic [31:0] WB_fwd;
    logic        Br_taken;
    logic [31:0] Br_addr;
    logic [3:0]  SR;
    logic        WB_EN;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] ALU_Res;
    logic [31:0] Val_Rm;
    logic [3:0]  Dest;

    modport master (
        output freeze, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN,
        output EXE_CMD_IN, PC_IN, Val_Rn_IN, Val_Rm_IN, imm_IN,
        output Shift_operand_IN, Signed_imm_24_IN, Dest_IN,
        output sel_src1, sel_src2, MEM_fwd, WB_fwd,
        input  Br_taken, Br_addr, SR, WB_EN, MEM_R_EN, MEM_W_EN,
        input  ALU_Res, Val_Rm, Dest
    );

    modport slave (
        input  freeze, WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN,
        input  EXE_CMD_IN, PC_IN, Val_Rn_IN, Val_Rm_IN, imm_IN,
        input  Shift_operand_IN, Signed_imm_24_IN, Dest_IN,
        input  sel_src1, sel_src2, MEM_fwd, WB_fwd,
        output Br_taken, Br_addr, SR, WB_EN, MEM_R_EN, MEM_W_EN,
        output ALU_Res, Val_Rm, Dest
    );
endinterface

// File: rtl/exe_stage_core.sv
// Execute stage: operand forwarding, Val2 shifter, ALU + NZCV, status register,
// branch target, EXE/MEM register. Ports: clk, rst (async, active-low), bus (slave).
// Macro EXE_FWD_EN enables the forwarding muxes on Rn/Rm.
module exe_stage_core (
    input  logic            clk,
    input  logic            rst,
    exe_stage_core_if.slave bus
);
    logic [31:0] rn;
    logic [31:0] rm;
    logic [31:0] val2;
    logic [31:0] res;
    logic [32:0] sum;
    logic        c_f;
    logic        v_f;
    logic [11:0] op;
    logic [63:0] rot_imm;
    logic [63:0] rot_rm;

    logic [3:0]  sr_q,  sr_d;
    logic        wb_q,  mr_q,  mw_q;
    logic [31:0] res_q, rm_q;
    logic [3:0]  dst_q;

`ifdef EXE_FWD_EN
    always_comb begin
        case (bus.sel_src1)
            2'b01:   rn = bus.MEM_fwd;
            2'b10:   rn = bus.WB_fwd;
            default: rn = bus.Val_Rn_IN;
        endcase
        case (bus.sel_src2)
            2'b01:   rm = bus.MEM_fwd;
            2'b10:   rm = bus.WB_fwd;
            default: rm = bus.Val_Rm_IN;
        endcase
    end
`else
    assign rn = bus.Val_Rn_IN;
    assign rm = bus.Val_Rm_IN;
    wire unused_fwd = ^{bus.sel_src1, bus.sel_src2, bus.MEM_fwd, bus.WB_fwd};
`endif

    assign op = bus.Shift_operand_IN;

    // Rotates done as a right shift of the value concatenated with itself.
    assign rot_imm = {24'd0, op[7:0], 24'd0, op[7:0]} >> {op[11:8], 1'b0};
    assign rot_rm  = {rm, rm} >> op[11:7];

    always_comb begin
        val2 = rm;
        if (bus.MEM_R_EN_IN || bus.MEM_W_EN_IN) begin
            val2 = {20'd0, op};
        end else if (bus.imm_IN) begin
            val2 = rot_imm[31:0];
        end else begin
            case (op[6:5])
                2'b00:   val2 = rm << op[11:7];
                2'b01:   val2 = rm >> op[11:7];
                2'b10:   val2 = $signed(rm) >>> op[11:7];
                default: val2 = rot_rm[31:0];
            endcase
        end
    end

    // Logic/move ops keep C and V; arithmetic recomputes them.
    always_comb begin
        sum = 33'd0;
        c_f = sr_q[1];
        v_f = sr_q[0];
        case (bus.EXE_CMD_IN)
            4'b0001: sum = {1'b0, val2};
            4'b1001: sum = {1'b0, ~val2};
            4'b0010, 4'b0011: begin
                sum = {1'b0, rn} + {1'b0, val2}
                    + {32'd0, bus.EXE_CMD_IN[0] & sr_q[1]};
                c_f = sum[32];
                v_f = (rn[31] == val2[31]) && (sum[31] != rn[31]);
            end
            4'b0100, 4'b0101: begin
                sum = {1'b0, rn} - {1'b0, val2}
                    - {32'd0, bus.EXE_CMD_IN[0] & ~sr_q[1]};
                c_f = ~sum[32];
                v_f = (rn[31] != val2[31]) && (sum[31] != rn[31]);
            end
            4'b0110: sum = {1'b0, rn & val2};
            4'b0111: sum = {1'b0, rn | val2};
            4'b1000: sum = {1'b0, rn ^ val2};
            default: sum = 33'd0;
        endcase
    end

    assign res  = sum[31:0];
    assign sr_d = {res[31], res == 32'd0, c_f, v_f};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q  <= 4'd0;
            wb_q  <= 1'b0;
            mr_q  <= 1'b0;
            mw_q  <= 1'b0;
            res_q <= 32'd0;
            rm_q  <= 32'd0;
            dst_q <= 4'd0;
        end else if (!bus.freeze) begin
            if (bus.S_IN) sr_q <= sr_d;
            wb_q  <= bus.WB_EN_IN;
            mr_q  <= bus.MEM_R_EN_IN;
            mw_q  <= bus.MEM_W_EN_IN;
            res_q <= res;
            rm_q  <= rm;
            dst_q <= bus.Dest_IN;
        end
    end

    assign bus.Br_taken = bus.B_IN;
    assign bus.Br_addr  = bus.PC_IN
                        + {{6{bus.Signed_imm_24_IN[23]}}, bus.Signed_imm_24_IN, 2'b00};
    assign bus.SR       = sr_q;
    assign bus.WB_EN    = wb_q;
    assign bus.MEM_R_EN = mr_q;
    assign bus.MEM_W_EN = mw_q;
    assign bus.ALU_Res  = res_q;
    assign bus.Val_Rm   = rm_q;
    assign bus.Dest     = dst_q;
endmodule

// File: tb/tb_exe_stage_core.sv
// Self-checking bench for exe_stage_core: directed table, corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_exe_stage_core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_stage_core_if bus();
    exe_stage_core dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic        freeze, wb, mr, mw, b, s, imm;
        logic [3:0]  cmd;
        logic [31:0] pc, rn, rm;
        logic [11:0] op;
        logic [23:0] imm24;
        logic [3:0]  dest;
        logic [1:0]  sel1, sel2;
        logic [31:0] memf, wbf;
    } in_t;

    typedef struct {
        logic [3:0]  cmd;
        logic        s, imm, mr;
        logic [31:0] rn, rm;
        logic [11:0] op;
        logic [31:0] res;
        logic [3:0]  sr;
    } vec_t;

    localparam longint MAXS = 64'sh7FFFFFFF;
    localparam longint MINS = -64'sh80000000;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_res, m_rm;
    logic [3:0]  m_sr, m_dest;
    logic [2:0]  m_ctl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic in_t zin();
        in_t x;
        x = '{default: '0};
        return x;
    endfunction

    task automatic drive(input in_t x);
        bus.freeze           = x.freeze;
        bus.WB_EN_IN         = x.wb;
        bus.MEM_R_EN_IN      = x.mr;
        bus.MEM_W_EN_IN      = x.mw;
        bus.B_IN             = x.b;
        bus.S_IN             = x.s;
        bus.EXE_CMD_IN       = x.cmd;
        bus.PC_IN            = x.pc;
        bus.Val_Rn_IN        = x.rn;
        bus.Val_Rm_IN        = x.rm;
        bus.imm_IN           = x.imm;
        bus.Shift_operand_IN = x.op;
        bus.Signed_imm_24_IN = x.imm24;
        bus.Dest_IN          = x.dest;
        bus.sel_src1         = x.sel1;
        bus.sel_src2         = x.sel2;
        bus.MEM_fwd          = x.memf;
        bus.WB_fwd           = x.wbf;
    endtask

    function automatic logic [31:0] rot_r(input logic [31:0] v, input int n);
        logic [31:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
        return r;
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] reg_v,
                                        input logic [31:0] mf, input logic [31:0] wf);
`ifdef EXE_FWD_EN
        if (sel == 2'd1) return mf;
        if (sel == 2'd2) return wf;
`else
        if (sel == 2'd3 && mf == wf) return reg_v;
`endif
        return reg_v;
    endfunction

    function automatic logic [31:0] val2_of(input in_t x, input logic [31:0] rm);
        int n;
        logic [31:0] r;
        longint unsigned u;
        if (x.mr || x.mw) return {20'd0, x.op};
        if (x.imm) return rot_r({24'd0, x.op[7:0]}, 2 * int'(x.op[11:8]));
        n = int'(x.op[11:7]);
        u = 64'(rm);
        case (x.op[6:5])
            2'd0: return 32'(u * (64'd1 << n));
            2'd1: return 32'(u / (64'd1 << n));
            2'd2: begin
                r = rm;
                for (int i = 0; i < n; i++) r = {r[31], r[31:1]};
                return r;
            end
            default: return rot_r(rm, n);
        endcase
    endfunction

    function automatic void model(input in_t x, input logic [3:0] sr,
                                  output logic [31:0] res, output logic [3:0] nsr,
                                  output logic [31:0] rmv, output logic [31:0] ba);
        logic [31:0] rn, v2;
        longint unsigned ua, ub, ci;
        longint sa, sb, s;
        logic c, v;
        rn  = fwd(x.sel1, x.rn, x.memf, x.wbf);
        rmv = fwd(x.sel2, x.rm, x.memf, x.wbf);
        v2  = val2_of(x, rmv);
        ua = 64'(rn);
        ub = 64'(v2);
        sa = longint'($signed(rn));
        sb = longint'($signed(v2));
        c = sr[1];
        v = sr[0];
        res = 32'd0;
        case (x.cmd)
            4'd1: res = v2;
            4'd9: res = ~v2;
            4'd6: res = rn & v2;
            4'd7: res = rn | v2;
            4'd8: res = rn ^ v2;
            4'd2, 4'd3: begin
                ci  = (x.cmd == 4'd3 && sr[1]) ? 64'd1 : 64'd0;
                res = 32'(ua + ub + ci);
                c   = (ua + ub + ci) > 64'hFFFFFFFF;
                s   = sa + sb + longint'(ci);
                v   = (s > MAXS) || (s < MINS);
            end
            4'd4, 4'd5: begin
                ci  = (x.cmd == 4'd5 && !sr[1]) ? 64'd1 : 64'd0;
                res = 32'(ua - ub - ci);
                c   = ua >= ub + ci;
                s   = sa - sb - longint'(ci);
                v   = (s > MAXS) || (s < MINS);
            end
            default: res = 32'd0;
        endcase
        nsr = {res[31], res == 32'd0, c, v};
        ba  = 32'(longint'(x.pc) + longint'($signed(x.imm24)) * 4);
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic in_t rand_in();
        in_t x;
        int r;
        x = zin();
        r = $urandom_range(0, 7);
        x.freeze = ($urandom_range(0, 3) == 0);
        x.mr     = (r == 0);
        x.mw     = (r == 1);
        x.wb     = 1'($urandom_range(0, 1));
        x.b      = 1'($urandom_range(0, 1));
        x.s      = 1'($urandom_range(0, 1));
        x.imm    = 1'($urandom_range(0, 1));
        x.cmd    = 4'($urandom_range(0, 15));
        x.pc     = $urandom;
        x.rn     = pick32();
        x.rm     = pick32();
        x.op     = 12'($urandom_range(0, 4095));
        x.imm24  = 24'($urandom);
        x.dest   = 4'($urandom_range(0, 15));
        x.sel1   = 2'($urandom_range(0, 3));
        x.sel2   = 2'($urandom_range(0, 3));
        x.memf   = pick32();
        x.wbf    = pick32();
        return x;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, " SR"}, bus.SR, 0);
        chk({tag, " ctl"}, {bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN}, 0);
        chk({tag, " ALU_Res"}, bus.ALU_Res, 0);
        chk({tag, " Val_Rm"}, bus.Val_Rm, 0);
        chk({tag, " Dest"}, bus.Dest, 0);
    endtask

    vec_t tbl[16];

    initial begin
        in_t x;
        logic [31:0] r, rmv, ba;
        logic [3:0]  nsr;

        tbl[0]  = '{4'h2, 1'b1, 1'b1, 1'b0, 32'h7FFFFFFF, 32'h0, 12'h001, 32'h80000000, 4'b1001};
        tbl[1]  = '{4'h4, 1'b1, 1'b0, 1'b0, 32'h5, 32'h5, 12'h000, 32'h0, 4'b0110};
        tbl[2]  = '{4'h1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 12'h4FF, 32'hFF000000, 4'b0110};
        tbl[3]  = '{4'h3, 1'b1, 1'b1, 1'b0, 32'h1, 32'h0, 12'h001, 32'h3, 4'b0000};
        tbl[4]  = '{4'h5, 1'b1, 1'b1, 1'b0, 32'h5, 32'h0, 12'h002, 32'h2, 4'b0010};
        tbl[5]  = '{4'h9, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 12'h000, 32'hFFFFFFFF, 4'b1010};
        tbl[6]  = '{4'h6, 1'b1, 1'b0, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 12'h000, 32'hF000F000, 4'b1010};
        tbl[7]  = '{4'h7, 1'b0, 1'b0, 1'b0, 32'h0F, 32'hF0, 12'h000, 32'hFF, 4'b1010};
        tbl[8]  = '{4'h8, 1'b1, 1'b0, 1'b0, 32'hFF, 32'hFF, 12'h000, 32'h0, 4'b0110};
        tbl[9]  = '{4'h0, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 12'h000, 32'h0, 4'b0110};
        tbl[10] = '{4'h2, 1'b0, 1'b0, 1'b1, 32'h400, 32'h0, 12'h004, 32'h404, 4'b0110};
        tbl[11] = '{4'h1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80000000, 12'h240, 32'hF8000000, 4'b0110};
        tbl[12] = '{4'h1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hF1, 12'h260, 32'h1000000F, 4'b0110};
        tbl[13] = '{4'h1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h80000000, 12'hFA0, 32'h1, 4'b0110};
        tbl[14] = '{4'h4, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 12'h001, 32'hFFFFFFFF, 4'b1000};
        tbl[15] = '{4'h4, 1'b1, 1'b1, 1'b0, 32'h80000000, 32'h0, 12'h001, 32'h7FFFFFFF, 4'b0011};

        rst = 1'b0;
        drive(zin());
        #7;
        chk_zero("reset");
        chk("reset Br_taken", bus.Br_taken, 0);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            x = zin();
            x.cmd = tbl[i].cmd;
            x.s   = tbl[i].s;
            x.imm = tbl[i].imm;
            x.mr  = tbl[i].mr;
            x.rn  = tbl[i].rn;
            x.rm  = tbl[i].rm;
            x.op  = tbl[i].op;
            x.dest = 4'(i);
            drive(x);
            tick();
            chk($sformatf("tbl%0d ALU_Res", i), bus.ALU_Res, tbl[i].res);
            chk($sformatf("tbl%0d SR", i), bus.SR, tbl[i].sr);
            chk($sformatf("tbl%0d MEM_R_EN", i), bus.MEM_R_EN, tbl[i].mr);
            chk($sformatf("tbl%0d Dest", i), bus.Dest, i);
        end

        x = zin();
        x.b = 1'b1;
        x.pc = 32'h100;
        x.imm24 = 24'hFFFFFE;
        drive(x);
        #1;
        chk("branch Br_taken", bus.Br_taken, 1);
        chk("branch Br_addr", bus.Br_addr, 32'hF8);
        tick();

        x = zin();
        x.mr = 1'b1;
        x.cmd = 4'h2;
        x.rn = 32'h400;
        x.op = 12'h004;
        drive(x);
        tick();
        chk("ldr ALU_Res", bus.ALU_Res, 32'h404);
        x = zin();
        x.freeze = 1'b1;
        x.b = 1'b1;
        x.s = 1'b1;
        x.cmd = 4'h1;
        x.imm = 1'b1;
        x.wb = 1'b1;
        x.dest = 4'hA;
        drive(x);
        #1;
        chk("freeze Br_taken", bus.Br_taken, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("freeze ALU_Res", bus.ALU_Res, 32'h404);
            chk("freeze MEM_R_EN", bus.MEM_R_EN, 1);
            chk("freeze WB_EN", bus.WB_EN, 0);
            chk("freeze SR", bus.SR, 4'b0011);
        end

        x = zin();
        x.sel1 = 2'b01;
        x.memf = 32'd10;
        x.rn = 32'd3;
        x.cmd = 4'h2;
        x.imm = 1'b1;
        x.op = 12'h001;
        drive(x);
        tick();
`ifdef EXE_FWD_EN
        chk("fwd ALU_Res", bus.ALU_Res, 32'd11);
`else
        chk("fwd ALU_Res", bus.ALU_Res, 32'd4);
`endif

        #2;
        rst = 1'b0;
        drive(zin());
        #1;
        chk_zero("midreset");
        chk("midreset Br_taken", bus.Br_taken, 0);
        #1;
        rst = 1'b1;
        m_res = 0;
        m_rm = 0;
        m_sr = 0;
        m_dest = 0;
        m_ctl = 0;

        for (int k = 0; k < 400; k++) begin
            x = rand_in();
            drive(x);
            model(x, m_sr, r, nsr, rmv, ba);
            #1;
            chk("rand Br_taken", bus.Br_taken, x.b);
            chk("rand Br_addr", bus.Br_addr, ba);
            tick();
            if (!x.freeze) begin
                m_res = r;
                m_rm = rmv;
                m_dest = x.dest;
                m_ctl = {x.wb, x.mr, x.mw};
                if (x.s) m_sr = nsr;
            end
            chk("rand ALU_Res", bus.ALU_Res, m_res);
            chk("rand SR", bus.SR, m_sr);
            chk("rand Val_Rm", bus.Val_Rm, m_rm);
            chk("rand Dest", bus.Dest, m_dest);
            chk("rand ctl", {bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN}, m_ctl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
